// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU fetch/data RAM arbiter.
package mem_arb_pkg;

  // Width of the fetch starvation counter.
  localparam int STARVE_W = 4;

  // Records which port owns the RAM read data returning next cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_src_e;

  // Starvation counter update: count up to lim while fetch loses, otherwise clear.
  function automatic logic [STARVE_W-1:0] starve_next(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] lim,
    input logic                lost
  );
    if (!lost)     return '0;
    if (cnt >= lim) return lim;
    return cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side (fetch + data) and RAM-side signals of the arbiter.
// slave: the arbiter's view. master: the CPU/RAM environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  // fetch port
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  // data port
  logic              d_req;
  logic [3:0]        d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // RAM port
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wen;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_wen, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_wen, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read RAM between the CPU fetch and data
// ports. Data has fixed priority; a saturating loss counter forces a fetch
// grant once fetch has lost STARVE_LIMIT times in a row. Read data is steered
// back to whichever port was granted in the previous cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_cnt_d;
  resp_src_e           resp_src;
  resp_src_e           resp_src_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [3:0]          wen_d;
  logic                i_gnt;
  logic                d_gnt;
  logic                fetch_starved;

  // Address bits outside the word index are deliberately dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  // Grant decision: data wins unless fetch has been starved to the limit.
  // Grants are gated by reset so nothing reaches the RAM while rst is high.
  always_comb begin
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    fetch_starved = (starve_cnt == LIMIT);
    if (!rst) begin
      if (bus.d_req && !(bus.i_req && fetch_starved)) d_gnt = 1'b1;
      else if (bus.i_req)                             i_gnt = 1'b1;
    end
  end

  // RAM command mux and next-state for the response owner and loss counter.
  always_comb begin
    addr_d       = addr_q;
    wen_d        = 4'b0000;
    resp_src_d   = RESP_NONE;
    starve_cnt_d = starve_next(starve_cnt, LIMIT, bus.i_req && d_gnt);
    if (d_gnt) begin
      addr_d = bus.d_addr[ADDR_W+1:2];
      wen_d  = bus.d_we;
      if (bus.d_we == 4'b0000) resp_src_d = RESP_DATA;
    end else if (i_gnt) begin
      addr_d     = bus.i_addr[ADDR_W+1:2];
      resp_src_d = RESP_INST;
    end
  end

  // State: loss counter, owner of next-cycle read data, last RAM address.
  // Reset drops any in-flight response; requesters re-issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_src   <= RESP_NONE;
      addr_q     <= '0;
    end else begin
      starve_cnt <= starve_cnt_d;
      resp_src   <= resp_src_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.m_addr   = addr_d;
  assign bus.m_wen    = wen_d;
  assign bus.m_wdata  = bus.d_wdata;
  assign bus.i_rvalid = (resp_src == RESP_INST);
  assign bus.d_rvalid = (resp_src == RESP_DATA);
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 256-word byte-writable synchronous RAM.
// Table vectors, hand-written multi-cycle sequences, then random traffic
// checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int ADDR_W = 22;
  localparam int LIM    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM with a bench-side preload port
  logic [31:0] ram [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_data;
    else
      for (int b = 0; b < 4; b++)
        if (bus.m_wen[b]) ram[bus.m_addr[7:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    bus.m_rdata <= ram[bus.m_addr[7:0]];
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic [3:0] dw, input logic [31:0] da, input logic [31:0] wd);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ram_load(input logic [7:0] idx, input logic [31:0] dat);
    ld_en = 1'b1; ld_idx = idx; ld_data = dat;
    tick();
    ld_en = 1'b0;
  endtask

  // Response check one cycle after a grant: kind 0 none, 1 fetch, 2 data.
  task automatic chk_rsp(input string nm, input int kind, input logic [31:0] dat);
    chk({nm, ".i_rvalid"}, 32'(bus.i_rvalid), 32'(kind == 1));
    chk({nm, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(kind == 2));
    if (kind == 1) chk({nm, ".i_rdata"}, bus.i_rdata, dat);
    if (kind == 2) chk({nm, ".d_rdata"}, bus.d_rdata, dat);
  endtask

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic        dr;   logic [3:0]  dw;  logic [31:0] da;  logic [31:0] wd;
    logic        eig;  logic        edg; logic [3:0]  ewen; logic [21:0] ema;
    int          ersp; logic [31:0] edat;
  } vec_t;

  function automatic vec_t mkv(logic ir, logic [31:0] ia, logic dr, logic [3:0] dw,
                               logic [31:0] da, logic [31:0] wd, logic eig, logic edg,
                               logic [3:0] ewen, logic [21:0] ema, int ersp, logic [31:0] edat);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
    v.eig = eig; v.edg = edg; v.ewen = ewen; v.ema = ema; v.ersp = ersp; v.edat = edat;
    return v;
  endfunction

  vec_t tbl [11];

  // Both ports request every cycle for 6 cycles starting from a cleared counter:
  // data wins LIM times, then fetch, then data again.
  task automatic both_seq(input string nm);
    for (int c = 0; c < 6; c++) begin
      drv(1'b1, 32'h8, 1'b1, 4'b0000, 32'h4, 32'h0);
      #1;
      chk($sformatf("%s.c%0d.i_gnt", nm, c), 32'(bus.i_gnt), 32'(c == LIM));
      chk($sformatf("%s.c%0d.d_gnt", nm, c), 32'(bus.d_gnt), 32'(c != LIM));
      tick();
      if (c == LIM) chk_rsp($sformatf("%s.c%0d", nm, c), 1, 32'h00000013);
      else          chk_rsp($sformatf("%s.c%0d", nm, c), 2, 32'hFFFFABFF);
    end
  endtask

  // random-phase model state
  logic [31:0] mdl [16];
  int          losses;
  logic        r_ir, r_dr, iwin, dwin;
  logic [31:0] r_ia, r_da, r_wd, ed;
  logic [3:0]  r_dw;
  int          ek;

  function automatic logic [31:0] mkaddr();
    logic [31:0] r;
    logic [3:0]  idx;
    r   = $urandom;
    idx = 4'($urandom_range(0, 15));
    return {r[31:10], 4'b0000, idx, r[1:0]};
  endfunction

  initial begin
    tbl[0]  = mkv(1, 32'h8,        0, 4'h0, 32'h0,        32'h0,        1, 0, 4'h0, 22'h2, 1, 32'h00000013);
    tbl[1]  = mkv(0, 32'h0,        1, 4'h2, 32'h4,        32'h0000AB00, 0, 1, 4'h2, 22'h1, 0, 32'h0);
    tbl[2]  = mkv(0, 32'h0,        1, 4'h0, 32'h4,        32'h0,        0, 1, 4'h0, 22'h1, 2, 32'hFFFFABFF);
    tbl[3]  = mkv(0, 32'h0,        1, 4'hF, 32'hC,        32'h11223344, 0, 1, 4'hF, 22'h3, 0, 32'h0);
    tbl[4]  = mkv(0, 32'h0,        1, 4'h0, 32'hC,        32'h0,        0, 1, 4'h0, 22'h3, 2, 32'h11223344);
    tbl[5]  = mkv(1, 32'h10,       1, 4'h0, 32'hC,        32'h0,        0, 1, 4'h0, 22'h3, 2, 32'h11223344);
    tbl[6]  = mkv(1, 32'h8,        0, 4'h0, 32'h0,        32'h0,        1, 0, 4'h0, 22'h2, 1, 32'h00000013);
    tbl[7]  = mkv(0, 32'h0,        1, 4'h0, 32'hFF000004, 32'h0,        0, 1, 4'h0, 22'h1, 2, 32'hFFFFABFF);
    tbl[8]  = mkv(0, 32'h8,        0, 4'h0, 32'h0,        32'h0,        0, 0, 4'h0, 22'h1, 0, 32'h0);
    tbl[9]  = mkv(0, 32'h0,        1, 4'hC, 32'h14,       32'hDEAD0000, 0, 1, 4'hC, 22'h5, 0, 32'h0);
    tbl[10] = mkv(0, 32'h0,        1, 4'h0, 32'h14,       32'h0,        0, 1, 4'h0, 22'h5, 2, 32'hDEADBEEF);

    // reset: requests present but nothing may be granted or written
    rst = 1'b1;
    drv(1'b1, 32'h8, 1'b1, 4'hF, 32'h14, 32'h55);
    #1;
    chk("rst.i_gnt",    32'(bus.i_gnt),    32'd0);
    chk("rst.d_gnt",    32'(bus.d_gnt),    32'd0);
    chk("rst.m_wen",    32'(bus.m_wen),    32'd0);
    chk("rst.m_addr",   32'(bus.m_addr),   32'd0);
    chk("rst.i_rvalid", 32'(bus.i_rvalid), 32'd0);
    chk("rst.d_rvalid", 32'(bus.d_rvalid), 32'd0);
    drv(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    ram_load(8'd1, 32'hFFFFFFFF);
    ram_load(8'd2, 32'h00000013);
    ram_load(8'd3, 32'h00000000);
    ram_load(8'd5, 32'h0000BEEF);
    rst = 1'b0;

    // table vectors, applied back-to-back
    for (int v = 0; v < 11; v++) begin
      drv(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dw, tbl[v].da, tbl[v].wd);
      #1;
      chk($sformatf("v%0d.i_gnt", v),  32'(bus.i_gnt),  32'(tbl[v].eig));
      chk($sformatf("v%0d.d_gnt", v),  32'(bus.d_gnt),  32'(tbl[v].edg));
      chk($sformatf("v%0d.m_wen", v),  32'(bus.m_wen),  32'(tbl[v].ewen));
      chk($sformatf("v%0d.m_addr", v), 32'(bus.m_addr), 32'(tbl[v].ema));
      tick();
      chk_rsp($sformatf("v%0d", v), tbl[v].ersp, tbl[v].edat);
    end

    // starvation: fetch wins on the LIM+1'th contested cycle
    both_seq("starve");

    // alternating fetch / data reads, one response per cycle on the right port
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drv(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
      else            drv(1'b0, 32'h0, 1'b1, 4'h0, 32'hC, 32'h0);
      #1;
      chk($sformatf("alt%0d.gnt", k), {30'd0, bus.i_gnt, bus.d_gnt},
          (k % 2 == 0) ? 32'd2 : 32'd1);
      tick();
      if (k % 2 == 0) chk_rsp($sformatf("alt%0d", k), 1, 32'h00000013);
      else            chk_rsp($sformatf("alt%0d", k), 2, 32'h11223344);
    end

    // reset between a fetch grant and its response: response dropped
    drv(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rstmid.i_gnt", 32'(bus.i_gnt), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    drv(1'b1, 32'h8, 1'b1, 4'hF, 32'h14, 32'h55);
    #1;
    chk("rstmid.gnt", {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
    chk("rstmid.m_wen", 32'(bus.m_wen), 32'd0);
    #1;
    drv(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.i_rvalid", 32'(bus.i_rvalid), 32'd0);
    chk("rstmid.d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rstmid.m_addr",   32'(bus.m_addr),   32'd0);

    // reset clears a partially built loss count
    for (int c = 0; c < 3; c++) begin
      drv(1'b1, 32'h8, 1'b1, 4'h0, 32'h4, 32'h0);
      #1;
      chk($sformatf("pre%0d.d_gnt", c), 32'(bus.d_gnt), 32'd1);
      tick();
    end
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #1;
    both_seq("post_rst");

    // random traffic against a transaction-level model
    drv(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      mdl[k] = $urandom;
      ram_load(8'(k), mdl[k]);
    end
    losses = 0;
    r_ir = 1'b0; r_dr = 1'b0;
    r_ia = '0; r_da = '0; r_wd = '0; r_dw = '0;
    for (int n = 0; n < 400; n++) begin
      if (!r_ir && $urandom_range(0, 2) != 0) begin
        r_ir = 1'b1; r_ia = mkaddr();
      end
      if (!r_dr && $urandom_range(0, 2) != 0) begin
        r_dr = 1'b1; r_da = mkaddr(); r_wd = $urandom;
        r_dw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      drv(r_ir, r_ia, r_dr, r_dw, r_da, r_wd);
      dwin   = r_dr && !(r_ir && losses >= LIM);
      iwin   = r_ir && !dwin;
      losses = (r_ir && dwin) ? ((losses + 1 > LIM) ? LIM : losses + 1) : 0;
      #1;
      chk($sformatf("rnd%0d.i_gnt", n), 32'(bus.i_gnt), 32'(iwin));
      chk($sformatf("rnd%0d.d_gnt", n), 32'(bus.d_gnt), 32'(dwin));
      chk($sformatf("rnd%0d.m_wen", n), 32'(bus.m_wen), dwin ? 32'(r_dw) : 32'd0);
      if (dwin)      chk($sformatf("rnd%0d.m_addr", n), 32'(bus.m_addr), 32'(r_da[23:2]));
      else if (iwin) chk($sformatf("rnd%0d.m_addr", n), 32'(bus.m_addr), 32'(r_ia[23:2]));
      ek = 0; ed = '0;
      if (iwin) begin
        ek = 1; ed = mdl[r_ia[5:2]];
      end else if (dwin) begin
        if (r_dw == 4'h0) begin
          ek = 2; ed = mdl[r_da[5:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (r_dw[b]) mdl[r_da[5:2]][8*b +: 8] = r_wd[8*b +: 8];
        end
      end
      tick();
      chk_rsp($sformatf("rnd%0d", n), ek, ed);
      if (iwin) r_ir = 1'b0;
      if (dwin) r_dr = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
